psum_drain: RTL and testbench
=============================

PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 Parameter DATA_BITWIDTH, default 32: psum word width.
REQ-002 Parameter BANK_NUM, default 3: GLB bank count.
REQ-003 Parameter BANK_DEPTH, default 8192: words per GLB bank; AW = clogb2(BANK_DEPTH-1) = 13.
REQ-004 Parameter FIFO_DEPTH, default 4: elastic buffer entries, power of two.
REQ-005 Port i_clk, input, 1: single clock, rising edge.
REQ-006 Port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port i_start, input, 1: one-cycle start pulse.
REQ-008 Port i_bank_sel, input, clogb2(BANK_NUM-1): target psum bank.
REQ-009 Port i_base_addr, input, AW: first write address.
REQ-010 Port i_num_elem, input, AW+1: number of psums to drain.
REQ-011 Port i_psum_valid, input, 1: PE_array psum_out valid.
REQ-012 Port i_psum_data, input, DATA_BITWIDTH: PE_array psum_out data.
REQ-013 Port o_psum_ready, output, 1: psum_out ready to PE_array.
REQ-014 Port o_glb_we, output, 1: GLB write enable.
REQ-015 Port o_glb_wa, output, AW: GLB write address.
REQ-016 Port o_glb_wd, output, DATA_BITWIDTH: GLB write data.
REQ-017 Port o_glb_bank_sel, output, clogb2(BANK_NUM-1): GLB bank select.
REQ-018 Port o_busy, output, 1: drain in progress.
REQ-019 Port o_done, output, 1: one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, FLUSH and DONE.
REQ-021 In IDLE, i_start SHALL latch bank_sel, base_addr and num_elem, clear both counters and enter RUN; if num_elem==0 it SHALL enter DONE instead.
REQ-022 An i_start pulse outside IDLE SHALL be ignored.
REQ-023 o_psum_ready SHALL equal (state==RUN) && !fifo_full && (accept_cnt < num_elem).
REQ-024 A transfer SHALL occur when i_psum_valid && o_psum_ready; the word is pushed into the FIFO and accept_cnt increments.
REQ-025 When accept_cnt reaches num_elem, RUN SHALL transition to FLUSH.
REQ-026 Whenever the FIFO is non-empty in RUN or FLUSH, one word SHALL be popped per cycle and drive o_glb_we=1, o_glb_wa=(base_addr+write_cnt) mod BANK_DEPTH and o_glb_wd=word, all registered; write_cnt then increments.
REQ-027 Latency from an accepted input to its o_glb_we SHALL be 2 cycles when the FIFO is otherwise empty.
REQ-028 A push and a pop in the same cycle SHALL both occur, leaving the occupancy unchanged.
REQ-029 FLUSH SHALL go to DONE in the cycle after the write with write_cnt==num_elem-1 is issued.
REQ-030 DONE SHALL assert o_done for exactly one cycle and then return to IDLE.
REQ-031 o_busy SHALL be 1 in RUN and FLUSH.
REQ-032 o_glb_bank_sel SHALL hold the latched bank value.
REQ-033 Writes issued in order SHALL follow input order; no words are dropped or duplicated.

Reset
REQ-034 Asserting i_rst_n low at any time, including mid-drain, SHALL force IDLE, empty the FIFO and zero all counters.
REQ-035 Every output (o_psum_ready, o_glb_we, o_glb_wa, o_glb_wd, o_glb_bank_sel, o_busy, o_done) SHALL reset to 0.

Configuration
REQ-036 With PSUM_DRAIN_RELU_EN defined, o_glb_wd SHALL be 0 whenever the signed popped word is negative and the word unchanged otherwise.
REQ-037 Without PSUM_DRAIN_RELU_EN, o_glb_wd SHALL be the raw word, with no extra logic and identical latency.

Structure
REQ-038 Package eyeriss_pkg SHALL hold the clogb2 function and the drain state enum (IDLE, RUN, FLUSH, DONE).
REQ-039 The FIFO SHALL be the sub-module psum_fifo, parameterised by DATA_BITWIDTH and FIFO_DEPTH, providing full/empty flags and simultaneous push/pop.

Verification
REQ-040 Bench SHALL cover all of the following scenarios:
- Start with base=2704, num=2704, valid held high, data=i: 2704 writes to addresses 2704..5407 with wd=i, o_done once, then IDLE.
- Random valid, 30% duty, num=10: 10 writes in order with no gaps in wa, and o_psum_ready low after the 10th accept.
- GLB stalling the producer so the FIFO fills: o_psum_ready low at 4 entries, no data loss.
- base=8190, num=4: wa sequence 8190, 8191, 0, 1.
- num=0: o_done 1 cycle after the start-accept cycle, with zero writes; a second start while busy is ignored.
- Reset mid-run after 5 accepts: all outputs 0 next cycle, and a fresh start behaves normally.
- RELU_EN only: data 0xFFFFFFF6 written as 0; data 0x00000007 written as 7.

Source files
------------

// File: rtl/eyeriss_pkg.sv
// Shared definitions for the psum drain path: bit-width helper and drain FSM states.
package eyeriss_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } drain_state_e;

   // Bits needed to hold 'value' (at least 1), e.g. clogb2(8191) = 13.
   function automatic int clogb2(input int value);
      int v;
      int n;
      v = value;
      n = 0;
      while (v > 0) begin
         n++;
         v = v >> 1;
      end
      return (n == 0) ? 1 : n;
   endfunction

endpackage

// File: rtl/psum_fifo.sv
// Show-ahead elastic buffer between PE_array psum_out and GLB writes.
// A push and a pop in the same cycle both take effect; a push while full is dropped.
module psum_fifo
   import eyeriss_pkg::*;
#(
   parameter int DATA_BITWIDTH = 32,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [DATA_BITWIDTH-1:0] i_data,
   input  logic                     i_pop,
   output logic [DATA_BITWIDTH-1:0] o_data,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PW = clogb2(FIFO_DEPTH - 1);

   logic [DATA_BITWIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW:0]              wr_ptr;
   logic [PW:0]              rd_ptr;
   logic                     do_push;
   logic                     do_pop;

   // Extra pointer MSB tells a full buffer apart from an empty one.
   assign o_empty = (wr_ptr == rd_ptr);
   assign o_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;
   assign o_data  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: state registers use <= so every flop samples pre-edge values.
         if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= i_data;
   end

endmodule

// File: rtl/psum_drain.sv
// Drains psums from PE_array into one GLB bank through a small elastic FIFO.
// Optional ReLU on written words: define PSUM_DRAIN_RELU_EN.
module psum_drain
   import eyeriss_pkg::*;
#(
   parameter  int DATA_BITWIDTH = 32,
   parameter  int BANK_NUM      = 3,
   parameter  int BANK_DEPTH    = 8192,
   parameter  int FIFO_DEPTH    = 4,
   localparam int AW            = clogb2(BANK_DEPTH - 1),
   localparam int BW            = clogb2(BANK_NUM - 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [BW-1:0]            i_bank_sel,
   input  logic [AW-1:0]            i_base_addr,
   input  logic [AW:0]              i_num_elem,
   input  logic                     i_psum_valid,
   input  logic [DATA_BITWIDTH-1:0] i_psum_data,
   output logic                     o_psum_ready,
   output logic                     o_glb_we,
   output logic [AW-1:0]            o_glb_wa,
   output logic [DATA_BITWIDTH-1:0] o_glb_wd,
   output logic [BW-1:0]            o_glb_bank_sel,
   output logic                     o_busy,
   output logic                     o_done
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(BANK_DEPTH);

   drain_state_e state;
   drain_state_e state_n;

   logic [BW-1:0]            bank_q;
   logic [AW-1:0]            base_q;
   logic [AW:0]              num_q;
   logic [AW:0]              accept_cnt;
   logic [AW:0]              write_cnt;
   logic                     start_ok;
   logic                     push;
   logic                     pop;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [DATA_BITWIDTH-1:0] fifo_data;
   logic [DATA_BITWIDTH-1:0] wd_next;
   logic [AW:0]              wa_sum;
   logic [AW:0]              wa_wrap;

   psum_fifo #(
      .DATA_BITWIDTH (DATA_BITWIDTH),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  (i_psum_data),
      .i_pop   (pop),
      .o_data  (fifo_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      state_n      = state;
      o_psum_ready = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      pop          = 1'b0;
      start_ok     = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               start_ok = 1'b1;
               state_n  = (i_num_elem == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            o_busy       = 1'b1;
            o_psum_ready = !fifo_full && (accept_cnt < num_q);
            pop          = !fifo_empty;
            if (accept_cnt == num_q) state_n = FLUSH;
         end
         FLUSH: begin
            o_busy  = 1'b1;
            pop     = !fifo_empty;
            if (write_cnt == num_q) state_n = DONE;
         end
         DONE: begin
            o_done  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign push = i_psum_valid && o_psum_ready;

   // Bank-relative address wraps modulo BANK_DEPTH; one subtraction covers base + offset.
   assign wa_sum  = {1'b0, base_q} + {1'b0, write_cnt[AW-1:0]};
   assign wa_wrap = (wa_sum >= DEPTH_W) ? (wa_sum - DEPTH_W) : wa_sum;

`ifdef PSUM_DRAIN_RELU_EN
   assign wd_next = fifo_data[DATA_BITWIDTH-1] ? '0 : fifo_data;
`else
   assign wd_next = fifo_data;
`endif

   assign o_glb_bank_sel = bank_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         bank_q     <= '0;
         base_q     <= '0;
         num_q      <= '0;
         accept_cnt <= '0;
         write_cnt  <= '0;
         o_glb_we   <= 1'b0;
         o_glb_wa   <= '0;
         o_glb_wd   <= '0;
      end else begin
         state    <= state_n;
         o_glb_we <= pop;
         if (start_ok) begin
            bank_q     <= i_bank_sel;
            base_q     <= i_base_addr;
            num_q      <= i_num_elem;
            accept_cnt <= '0;
            write_cnt  <= '0;
         end else begin
            if (push) accept_cnt <= accept_cnt + (AW+1)'(1);
            if (pop)  write_cnt  <= write_cnt + (AW+1)'(1);
         end
         if (pop) begin
            o_glb_wa <= wa_wrap[AW-1:0];
            o_glb_wd <= wd_next;
         end
      end
   end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain (and its psum_fifo); honours PSUM_DRAIN_RELU_EN.
module tb_psum_drain;

   localparam int DW = 32;
   localparam int AW = 13;
   localparam int BW = 2;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [BW-1:0] i_bank_sel = '0;
   logic [AW-1:0] i_base_addr = '0;
   logic [AW:0]   i_num_elem = '0;
   logic          i_psum_valid = 1'b0;
   logic [DW-1:0] i_psum_data = '0;
   logic          o_psum_ready;
   logic          o_glb_we;
   logic [AW-1:0] o_glb_wa;
   logic [DW-1:0] o_glb_wd;
   logic [BW-1:0] o_glb_bank_sel;
   logic          o_busy;
   logic          o_done;

   logic          f_push = 1'b0;
   logic          f_pop = 1'b0;
   logic [DW-1:0] f_wdata = '0;
   logic [DW-1:0] f_rdata;
   logic          f_full;
   logic          f_empty;

   always #5 i_clk = ~i_clk;

   psum_drain u_dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_start        (i_start),
      .i_bank_sel     (i_bank_sel),
      .i_base_addr    (i_base_addr),
      .i_num_elem     (i_num_elem),
      .i_psum_valid   (i_psum_valid),
      .i_psum_data    (i_psum_data),
      .o_psum_ready   (o_psum_ready),
      .o_glb_we       (o_glb_we),
      .o_glb_wa       (o_glb_wa),
      .o_glb_wd       (o_glb_wd),
      .o_glb_bank_sel (o_glb_bank_sel),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   psum_fifo #(.DATA_BITWIDTH(DW), .FIFO_DEPTH(4)) u_fifo_solo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (f_push),
      .i_data  (f_wdata),
      .i_pop   (f_pop),
      .o_data  (f_rdata),
      .o_full  (f_full),
      .o_empty (f_empty)
   );

   int            n_checks = 0;
   int            n_pass = 0;
   int            done_cnt = 0;
   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   logic [DW-1:0] feed[$];

   // Write/done monitor, sampled mid-cycle.
   always @(negedge i_clk) begin
      if (o_glb_we) begin
         wa_q.push_back(o_glb_wa);
         wd_q.push_back(o_glb_wd);
      end
      if (o_done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [DW-1:0] exp_wd(input logic [DW-1:0] w);
`ifdef PSUM_DRAIN_RELU_EN
      return w[DW-1] ? '0 : w;
`else
      return w;
`endif
   endfunction

   function automatic logic [63:0] all_outs();
      return {13'd0, o_psum_ready, o_glb_we, o_glb_wa, o_glb_wd, o_glb_bank_sel, o_busy, o_done};
   endfunction

   // Start a drain, feed feed[0..num-1] at the given valid duty, wait for done, score writes.
   task automatic run_drain(input string tag, input int base, input int num, input int bank,
                            input int duty, input bit restart);
      int   k;
      int   cyc;
      int   idx0;
      int   d0;
      int   bad;
      int   nw;
      logic xfer;
      idx0 = wa_q.size();
      d0   = done_cnt;
      i_start     = 1'b1;
      i_base_addr = base[AW-1:0];
      i_num_elem  = num[AW:0];
      i_bank_sel  = bank[BW-1:0];
      tick();
      i_start = 1'b0;
      if (restart) begin
         i_start     = 1'b1;
         i_base_addr = 13'd600;
         i_num_elem  = 14'd5;
         i_bank_sel  = 2'd2;
         tick();
         i_start = 1'b0;
      end
      check({tag, "_bank"}, o_glb_bank_sel, bank);
      check({tag, "_busy"}, o_busy, 1);
      k   = 0;
      cyc = 0;
      while (k < num && cyc < 20 * num + 100) begin
         i_psum_valid = ($urandom_range(99) < duty);
         i_psum_data  = feed[k];
         xfer = i_psum_valid && o_psum_ready;
         tick();
         cyc++;
         if (xfer) k++;
      end
      i_psum_valid = 1'b0;
      check({tag, "_accepts"}, k, num);
      check({tag, "_ready_low_after_last"}, o_psum_ready, 0);
      cyc = 0;
      while (!o_done && cyc < 200) begin
         tick();
         cyc++;
      end
      check({tag, "_done_seen"}, o_done, 1);
      tick();
      tick();
      check({tag, "_idle_after"}, {o_busy, o_done}, 0);
      check({tag, "_done_once"}, done_cnt - d0, 1);
      nw = wa_q.size() - idx0;
      check({tag, "_nwrites"}, nw, num);
      bad = 0;
      for (int i = 0; i < nw && i < num; i++) begin
         if (wa_q[idx0 + i] !== AW'((base + i) % 8192)) bad++;
         if (wd_q[idx0 + i] !== exp_wd(feed[i])) bad++;
      end
      check({tag, "_order"}, bad, 0);
   endtask

   initial begin
      int   k;
      int   cyc;
      int   i0;
      int   d0;
      logic xfer;

      // Reset state
      tick();
      check("reset_outputs", all_outs(), 0);
      i_rst_n = 1'b1;
      tick();
      check("idle_outputs", all_outs(), 0);

      // Single word: accept -> o_glb_we two cycles later, done pulse after the flush
      i_start = 1'b1; i_base_addr = 13'd5; i_num_elem = 14'd1; i_bank_sel = 2'd1;
      tick();
      i_start = 1'b0;
      i_psum_valid = 1'b1; i_psum_data = 32'h1234;
      check("lat_ready", o_psum_ready, 1);
      tick();
      i_psum_valid = 1'b0;
      check("lat_we_cycle1", o_glb_we, 0);
      tick();
      check("lat_we_cycle2", {o_glb_we, o_glb_wa, o_glb_wd}, {1'b1, 13'd5, 32'h1234});
      tick();
      check("lat_done", o_done, 1);
      tick();
      check("lat_idle", {o_done, o_busy}, 0);

      // Long drain, valid held high, data = index
      feed.delete();
      for (int i = 0; i < 2704; i++) feed.push_back(i);
      run_drain("long", 2704, 2704, 0, 100, 1'b0);

      // Random valid at 30% duty
      feed.delete();
      for (int i = 0; i < 10; i++) feed.push_back(32'hA000 + i);
      run_drain("rand30", 100, 10, 2, 30, 1'b0);

      // Address wrap at bank end
      feed.delete();
      for (int i = 0; i < 4; i++) feed.push_back(32'h55 + i);
      run_drain("wrap", 8190, 4, 1, 100, 1'b0);
      check("wrap_last_wa", wa_q[wa_q.size() - 1], 13'd1);

      // num_elem == 0: done one cycle after start, no writes
      i0 = wa_q.size();
      d0 = done_cnt;
      i_start = 1'b1; i_base_addr = 13'd9; i_num_elem = 14'd0; i_bank_sel = 2'd0;
      tick();
      i_start = 1'b0;
      check("zero_done", {o_done, o_busy}, 2'b10);
      tick();
      check("zero_done_drop", o_done, 0);
      tick();
      check("zero_writes", wa_q.size() - i0, 0);
      check("zero_done_once", done_cnt - d0, 1);

      // Second start while busy is ignored
      feed.delete();
      for (int i = 0; i < 3; i++) feed.push_back(32'hC0DE0000 + i);
      run_drain("restart", 300, 3, 1, 100, 1'b1);

      // Reset mid-run after 5 accepts
      i_start = 1'b1; i_base_addr = 13'd40; i_num_elem = 14'd10; i_bank_sel = 2'd2;
      tick();
      i_start = 1'b0;
      k = 0;
      cyc = 0;
      while (k < 5 && cyc < 100) begin
         i_psum_valid = 1'b1;
         i_psum_data  = 32'hBEEF + k;
         xfer = o_psum_ready;
         tick();
         cyc++;
         if (xfer) k++;
      end
      i_psum_valid = 1'b0;
      check("midrst_accepts", k, 5);
      i_rst_n = 1'b0;
      tick();
      check("midrst_outputs", all_outs(), 0);
      i_rst_n = 1'b1;
      tick();
      check("midrst_idle", all_outs(), 0);
      feed.delete();
      for (int i = 0; i < 4; i++) feed.push_back(32'h700 + i);
      run_drain("post_rst", 7, 4, 1, 100, 1'b0);

      // Sign handling (ReLU when enabled, raw otherwise)
      feed.delete();
      feed.push_back(32'hFFFF_FFF6);
      feed.push_back(32'h0000_0007);
      feed.push_back(32'h8000_0000);
      feed.push_back(32'h0000_0012);
      i0 = wd_q.size();
      run_drain("sign", 20, 4, 0, 100, 1'b0);
`ifdef PSUM_DRAIN_RELU_EN
      check("relu_neg", wd_q[i0], 32'h0);
`else
      check("raw_neg", wd_q[i0], 32'hFFFF_FFF6);
`endif
      check("pos_word", wd_q[i0 + 1], 32'h7);

      // Elastic buffer fills at four entries, keeps order, concurrent push/pop
      check("fifo_empty_init", {f_empty, f_full}, 2'b10);
      for (int i = 0; i < 4; i++) begin
         f_push = 1'b1;
         f_wdata = 32'h11 * (i + 1);
         tick();
         if (i == 2) check("fifo_not_full_at_3", f_full, 0);
      end
      check("fifo_full_at_4", f_full, 1);
      f_wdata = 32'hDEAD;
      tick();
      f_push = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fifo_pop_%0d", i), f_rdata, 32'h11 * (i + 1));
         f_pop = 1'b1;
         tick();
         f_pop = 1'b0;
      end
      check("fifo_empty_after", f_empty, 1);
      f_push = 1'b1; f_wdata = 32'hAA;
      tick();
      f_wdata = 32'hBB; f_pop = 1'b1;
      tick();
      f_push = 1'b0; f_pop = 1'b0;
      check("fifo_pushpop", {f_empty, f_full, f_rdata}, {2'b00, 32'hBB});
      f_pop = 1'b1;
      tick();
      f_pop = 1'b0;
      check("fifo_drained", f_empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
